// File: rtl/pcap_replay_axis_unpacker.sv
// Replay FIFO unpacker: header/data words from a FWFT FIFO become AXI4-Stream
// packets, with the header's inter-packet gap enforced at the output port.
module pcap_replay_axis_unpacker #(
    parameter int         C_S_FIFO_WIDTH       = 144,
    parameter int         C_M_AXIS_DATA_WIDTH  = 128,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] SRC_PORT             = 8'h01
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_FIFO_WIDTH-1:0]         fifo_dout,
    input  logic                              fifo_empty,
    output logic                              fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic                              replay_en,
    output logic [31:0]                       pkt_count,
    output logic                              busy
);

    localparam int KW = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]                       r_len;
    logic [31:0]                       r_delay;
    logic [31:0]                       r_gap;
    logic [12:0]                       r_beats_left;
    logic [31:0]                       r_pkt_count;
    logic                              r_tvalid;
    logic                              r_tlast;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    r_tdata;
    logic [KW-1:0]                     r_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   r_tuser;

    logic                              w_hdr_pop;
    logic                              w_data_pop;
    logic                              w_last_hs;
    logic                              w_final;
    logic [16:0]                       w_len_sum;
    logic [12:0]                       w_hdr_beats;
    logic [KW-1:0]                     w_last_keep;
    logic                              w_unused;

    // 17-bit add so len=65535 rounds up to 4096 beats without overflow
    assign w_len_sum   = {1'b0, fifo_dout[15:0]} + 17'd15;
    assign w_hdr_beats = w_len_sum[16:4];
    assign w_last_hs   = r_tvalid & m_axis_tready & r_tlast;
    assign w_final     = (r_beats_left == 13'd1);
    assign w_last_keep = (r_len[3:0] == 4'd0) ? {KW{1'b1}}
                       : ((KW'(1) << r_len[3:0]) - KW'(1));
    assign w_unused    = ^fifo_dout[C_S_FIFO_WIDTH-1:C_M_AXIS_DATA_WIDTH];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_hdr_pop  = 1'b0;
        w_data_pop = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (replay_en) w_next = S_HDR;
            end
            S_HDR: begin
                if (!replay_en) begin
                    w_next = S_IDLE;
                end else if (!fifo_empty) begin
                    w_hdr_pop = 1'b1;
                    if (fifo_dout[15:0] != 16'd0)
                        w_next = S_DATA;
                    else if (fifo_dout[47:16] != 32'd0)
                        w_next = S_GAP;
                end
            end
            S_DATA: begin
                w_data_pop = !fifo_empty && (!r_tvalid || m_axis_tready)
                           && (r_beats_left != 13'd0);
                if (w_last_hs)
                    w_next = (r_delay != 32'd0) ? S_GAP : S_HDR;
            end
            S_GAP: begin
                if (r_gap <= 32'd1) w_next = S_HDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign fifo_rd_en = w_hdr_pop | w_data_pop;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_len        <= '0;
            r_delay      <= '0;
            r_gap        <= '0;
            r_beats_left <= '0;
            r_pkt_count  <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tuser      <= '0;
        end else begin
            if (w_hdr_pop) begin
                r_len        <= fifo_dout[15:0];
                r_delay      <= fifo_dout[47:16];
                r_gap        <= fifo_dout[47:16];
                r_beats_left <= w_hdr_beats;
            end
            // a pop refills the register even while the old beat is taken
            if (w_data_pop) begin
                r_tvalid     <= 1'b1;
                r_tdata      <= fifo_dout[C_M_AXIS_DATA_WIDTH-1:0];
                r_tuser      <= {{(C_M_AXIS_TUSER_WIDTH-24){1'b0}},
                                 SRC_PORT, r_len};
                r_tlast      <= w_final;
                r_tkeep      <= w_final ? w_last_keep : {KW{1'b1}};
                r_beats_left <= r_beats_left - 13'd1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (w_last_hs) begin
                r_pkt_count <= r_pkt_count + 32'd1;
                r_gap       <= r_delay;
            end else if (r_state == S_GAP && r_gap > 32'd1) begin
                r_gap <= r_gap - 32'd1;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tuser  = r_tuser;
    assign pkt_count     = r_pkt_count;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pcap_replay_axis_unpacker.sv
// Scoreboard bench for the replay unpacker: FIFO model in, expected beats
// queued per packet, monitor compares every accepted beat.
module tb_pcap_replay_axis_unpacker;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn;
    logic [143:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         replay_en;
    logic [31:0]  pkt_count;
    logic         busy;

    pcap_replay_axis_unpacker dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .replay_en     (replay_en),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [127:0] user;
    } beat_t;

    beat_t        exp_q[$];
    logic [143:0] fq[$];
    int           gap_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           exp_pkts = 0;
    int           beats_seen = 0;
    int           pops = 0;
    bit           pop_pend = 0;
    bit           starve = 0;
    bit           starve_mode = 0;
    bit           rdy_mode = 0;
    bit           stalled = 0;
    bit           after_last = 0;
    int           idle = 0;
    int           prev_delay = 0;
    beat_t        held;
    beat_t        e;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [143:0] rand144();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[143:0];
    endfunction

    task automatic refresh();
        fifo_empty = (fq.size() == 0) || starve;
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Reference: header word then ceil(len/16) data words; byte k of the
    // packet is valid iff k < len, tuser carries len and source port 1.
    task automatic send_pkt(input int len, input int delay);
        logic [143:0] w;
        beat_t        b;
        int           nb;
        w = rand144();
        w[15:0]  = len[15:0];
        w[47:16] = delay;
        fq.push_back(w);
        nb = (len + 15) / 16;
        for (int i = 0; i < nb; i++) begin
            w = rand144();
            fq.push_back(w);
            b.data = w[127:0];
            for (int k = 0; k < 16; k++) b.keep[k] = ((i * 16 + k) < len);
            b.last = (i == nb - 1);
            b.user = '0;
            b.user[15:0]  = len[15:0];
            b.user[23:16] = 8'h01;
            exp_q.push_back(b);
        end
        if (len != 0) begin
            gap_q.push_back(delay);
            exp_pkts++;
        end
        refresh();
    endtask

    task automatic cycle();
        @(posedge axi_aclk);
        #1;
        if (pop_pend && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        pop_pend = 0;
        m_axis_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        starve = starve_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
        refresh();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 128'(n < budget), 128'd1);
        cycles(4);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beats_seen < target && n < budget) begin
            cycle();
            n++;
        end
        check("beat_wait", 128'(n < budget), 128'd1);
    endtask

    always @(negedge axi_aclk) begin
        if (axi_aresetn) begin
            pop_pend = fifo_rd_en;
            if (fifo_rd_en) check("rd_en_nonempty", 128'(fifo_empty), 128'd0);
            if (stalled) begin
                check("stall_valid", 128'(m_axis_tvalid), 128'd1);
                check("stall_data", m_axis_tdata, held.data);
                check("stall_keep", 128'(m_axis_tkeep), 128'(held.keep));
                check("stall_last", 128'(m_axis_tlast), 128'(held.last));
            end
            if (after_last) begin
                if (m_axis_tvalid) begin
                    check("gap_min", 128'(idle >= prev_delay), 128'd1);
                    after_last = 0;
                end else begin
                    idle++;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tkeep", 128'(m_axis_tkeep), 128'(e.keep));
                    check("tlast", 128'(m_axis_tlast), 128'(e.last));
                    check("tuser", m_axis_tuser, e.user);
                end
                beats_seen++;
                if (m_axis_tlast) begin
                    after_last = 1;
                    idle = 0;
                    prev_delay = (gap_q.size() != 0) ? gap_q.pop_front() : 0;
                end
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held.data = m_axis_tdata;
            held.keep = m_axis_tkeep;
            held.last = m_axis_tlast;
            held.user = m_axis_tuser;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        axi_aresetn   = 1'b0;
        replay_en     = 1'b0;
        m_axis_tready = 1'b1;
        refresh();
        #22;
        check("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("rst_tlast", 128'(m_axis_tlast), 128'd0);
        check("rst_tdata", m_axis_tdata, 128'd0);
        check("rst_tkeep", 128'(m_axis_tkeep), 128'd0);
        check("rst_tuser", m_axis_tuser, 128'd0);
        check("rst_pkt_count", 128'(pkt_count), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rd_en", 128'(fifo_rd_en), 128'd0);
        @(posedge axi_aclk);
        #1;
        axi_aresetn = 1'b1;
        cycles(2);
        check("idle_busy", 128'(busy), 128'd0);

        replay_en = 1'b1;
        send_pkt(64, 0);
        wait_drain(500);
        check("pkt_count_t1", 128'(pkt_count), 128'(exp_pkts));

        send_pkt(65, 0);
        send_pkt(15, 0);
        wait_drain(500);
        check("pkt_count_t2", 128'(pkt_count), 128'(exp_pkts));

        send_pkt(0, 0);
        send_pkt(16, 0);
        send_pkt(0, 6);
        send_pkt(16, 0);
        wait_drain(500);
        check("pkt_count_t5", 128'(pkt_count), 128'(exp_pkts));

        rdy_mode = 1;
        p0 = pops;
        send_pkt(256, 0);
        wait_drain(2000);
        check("pops_t3", 128'(pops - p0), 128'd17);
        rdy_mode = 0;

        send_pkt(64, 10);
        send_pkt(64, 10);
        wait_drain(500);
        check("pkt_count_t4", 128'(pkt_count), 128'(exp_pkts));

        rdy_mode    = 1;
        starve_mode = 1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) == 0)
                send_pkt(0, $urandom_range(0, 5));
            else if ($urandom_range(0, 9) == 0)
                send_pkt($urandom_range(1000, 1600), $urandom_range(0, 12));
            else
                send_pkt($urandom_range(1, 300), $urandom_range(0, 12));
        end
        wait_drain(20000);
        check("pkt_count_rand", 128'(pkt_count), 128'(exp_pkts));
        rdy_mode    = 0;
        starve_mode = 0;
        cycle();

        p0 = beats_seen;
        send_pkt(64, 3);
        send_pkt(32, 0);
        wait_beats(p0 + 1, 200);
        replay_en = 1'b0;
        cycles(40);
        check("t7_left_beats", 128'(exp_q.size()), 128'd2);
        check("t7_left_words", 128'(fq.size()), 128'd3);
        check("t7_busy", 128'(busy), 128'd0);
        check("t7_pkt_count", 128'(pkt_count), 128'(exp_pkts - 1));
        replay_en = 1'b1;
        wait_drain(500);
        check("t7_pkt_count_end", 128'(pkt_count), 128'(exp_pkts));

        p0 = beats_seen;
        send_pkt(256, 0);
        wait_beats(p0 + 3, 200);
        #2;
        axi_aresetn = 1'b0;
        #1;
        check("arst_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("arst_tdata", m_axis_tdata, 128'd0);
        check("arst_tkeep", 128'(m_axis_tkeep), 128'd0);
        check("arst_tuser", m_axis_tuser, 128'd0);
        check("arst_tlast", 128'(m_axis_tlast), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_rd_en", 128'(fifo_rd_en), 128'd0);
        check("arst_pkt_count", 128'(pkt_count), 128'd0);
        fq.delete();
        exp_q.delete();
        gap_q.delete();
        exp_pkts   = 0;
        pop_pend   = 0;
        stalled    = 0;
        after_last = 0;
        refresh();
        cycles(2);
        axi_aresetn = 1'b1;
        send_pkt(48, 0);
        wait_drain(500);
        check("t6b_pkt_count", 128'(pkt_count), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
